key_event_decoder: RTL and testbench

Classifies debounced key activity into discrete user events: single click, double click, long press, and auto-repeat while held. It sits directly downstream of the key debounce filter and consumes that filter's one-cycle `key_flag` press pulse and level `key_state`. Its output is a one-cycle `evt_valid` strobe with a 2-bit `evt_code`. The dpram control logic uses these strobes as write/read commands.

---
 rtl/key_event_decoder.sv | 134 +++++++++++++
 tb/tb_key_event_decoder.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/key_event_decoder.sv
// Turns debounced key activity into single/double/long/repeat event strobes.
// One FSM with a shared timing counter; all outputs are registered.
module key_event_decoder #(
  parameter int CNT_W       = 26,
  parameter int LONG_CYC    = 50_000_000,
  parameter int DBL_WIN_CYC = 15_000_000,
  parameter int REPEAT_CYC  = 10_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_flag,
  input  logic       key_state,
  output logic       evt_valid,
  output logic [1:0] evt_code,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRESS1 = 3'd1,
    WAIT2  = 3'd2,
    PRESS2 = 3'd3,
    LONG   = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    EVT_SINGLE = 2'b00,
    EVT_DOUBLE = 2'b01,
    EVT_LONG   = 2'b10,
    EVT_REPEAT = 2'b11
  } evt_t;

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);
  localparam logic [CNT_W-1:0] DBL_LAST  = CNT_W'(DBL_WIN_CYC - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             key_state_d;
  logic             rel;

  // Only the falling edge of the debounced level counts as a release.
  assign rel = key_state_d & ~key_state;

  // NOTE: every register below uses <= so each branch reads the values from
  // before this edge; blocking assignments here would make later branches see
  // half-updated state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      key_state_d <= 1'b0;
      evt_valid   <= 1'b0;
      evt_code    <= EVT_SINGLE;
      busy        <= 1'b0;
    end else begin
      key_state_d <= key_state;
      evt_valid   <= 1'b0;

      case (state)
        // IDLE and PRESS2 have no timeout, so cnt is parked at 0 there
        // rather than free-running toward a wrap.
        IDLE: begin
          cnt <= '0;
          if (key_flag) begin
            state <= PRESS1;
            busy  <= 1'b1;
          end
        end

        PRESS1: begin
          if (rel) begin
            state <= WAIT2;
            cnt   <= '0;
          end else if (cnt == LONG_LAST) begin
            state     <= LONG;
            cnt       <= '0;
            evt_valid <= 1'b1;
            evt_code  <= EVT_LONG;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        WAIT2: begin
          if (key_flag) begin
            state     <= PRESS2;
            cnt       <= '0;
            evt_valid <= 1'b1;
            evt_code  <= EVT_DOUBLE;
          end else if (cnt == DBL_LAST) begin
            state     <= IDLE;
            cnt       <= '0;
            busy      <= 1'b0;
            evt_valid <= 1'b1;
            evt_code  <= EVT_SINGLE;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        PRESS2: begin
          cnt <= '0;
          if (rel) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end

        LONG: begin
          if (rel) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
          end else if (cnt == REP_LAST) begin
            cnt       <= '0;
            evt_valid <= 1'b1;
            evt_code  <= EVT_REPEAT;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        default: begin
          state <= IDLE;
          cnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_event_decoder.sv
// Directed bench for key_event_decoder: expected events are queued with their
// due cycle when stimulus is driven and matched by a negedge monitor.
module tb_key_event_decoder;

  localparam int LONG_CYC = 100;
  localparam int DBL_CYC  = 40;
  localparam int REP_CYC  = 20;

  logic       clk = 1'b0;
  logic       rst;
  logic       key_flag;
  logic       key_state;
  logic       evt_valid;
  logic [1:0] evt_code;
  logic       busy;

  typedef struct {
    logic [1:0] code;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_fail   = 0;

  key_event_decoder #(
    .CNT_W      (26),
    .LONG_CYC   (LONG_CYC),
    .DBL_WIN_CYC(DBL_CYC),
    .REPEAT_CYC (REP_CYC)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .key_flag (key_flag),
    .key_state(key_state),
    .evt_valid(evt_valid),
    .evt_code (evt_code),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // cyc == k at the negedge following the k-th rising edge.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  // Scoreboard monitor: evt_valid must be high exactly on queued cycles.
  always @(negedge clk) begin
    logic due;
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      check("evt_due_cycle", cyc, sb[0].cyc);
      void'(sb.pop_front());
    end
    due = (sb.size() > 0) && (sb[0].cyc == cyc);
    check("evt_valid", {31'b0, evt_valid}, {31'b0, due});
    if (due) begin
      check("evt_code", {30'b0, evt_code}, {30'b0, sb[0].code});
      void'(sb.pop_front());
    end
  end

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // Called at a negedge: flag, hold key_state for 'hold' cycles, drive release.
  // f = edge that enters PRESS1, w = edge that enters WAIT2.
  task automatic click(input int hold, output int f, output int w);
    key_flag = 1'b1;
    f = cyc + 1;
    @(negedge clk);
    key_flag  = 1'b0;
    key_state = 1'b1;
    check("click_busy_rise", {31'b0, busy}, 32'd1);
    repeat (hold) @(negedge clk);
    key_state = 1'b0;
    w = cyc + 1;
  endtask

  initial begin
    int f, w;
    rst       = 1'b0;
    key_flag  = 1'b0;
    key_state = 1'b0;

    // Reset held while inputs toggle.
    repeat (12) begin
      @(negedge clk);
      check("rst_evt_valid", {31'b0, evt_valid}, 32'd0);
      check("rst_evt_code", {30'b0, evt_code}, 32'd0);
      check("rst_busy", {31'b0, busy}, 32'd0);
      key_flag  = 1'($urandom);
      key_state = 1'($urandom);
    end
    @(negedge clk);
    key_flag  = 1'b0;
    key_state = 1'b0;
    rst       = 1'b1;
    wait_cyc(cyc + 30);
    check("post_rst_busy", {31'b0, busy}, 32'd0);

    // Single click.
    @(negedge clk);
    click(30, f, w);
    sb.push_back('{2'b00, w + DBL_CYC});
    @(negedge clk);
    check("single_wait2_busy", {31'b0, busy}, 32'd1);
    wait_cyc(w + DBL_CYC);
    check("single_busy_low", {31'b0, busy}, 32'd0);
    wait_cyc(w + DBL_CYC + 5);
    check("single_code_hold", {30'b0, evt_code}, 32'd0);
    check("single_sb_empty", sb.size(), 32'd0);

    // Double click: second flag 20 cycles after the release.
    @(negedge clk);
    click(30, f, w);
    wait_cyc(w + 19);
    key_flag = 1'b1;
    sb.push_back('{2'b01, cyc + 1});
    @(negedge clk);
    key_flag  = 1'b0;
    key_state = 1'b1;
    check("double_press2_busy", {31'b0, busy}, 32'd1);
    repeat (10) @(negedge clk);
    key_state = 1'b0;
    @(negedge clk);
    check("double_idle", {31'b0, busy}, 32'd0);
    wait_cyc(cyc + 60);
    check("double_code_hold", {30'b0, evt_code}, 32'd1);
    check("double_sb_empty", sb.size(), 32'd0);

    // Long press with auto-repeat, held 175 cycles.
    @(negedge clk);
    key_flag = 1'b1;
    f = cyc + 1;
    sb.push_back('{2'b10, f + LONG_CYC});
    sb.push_back('{2'b11, f + LONG_CYC + REP_CYC});
    sb.push_back('{2'b11, f + LONG_CYC + 2 * REP_CYC});
    sb.push_back('{2'b11, f + LONG_CYC + 3 * REP_CYC});
    @(negedge clk);
    key_flag  = 1'b0;
    key_state = 1'b1;
    wait_cyc(f + 175);
    key_state = 1'b0;
    @(negedge clk);
    check("long_release_idle", {31'b0, busy}, 32'd0);
    wait_cyc(cyc + 40);
    check("long_code_hold", {30'b0, evt_code}, 32'd3);
    check("long_sb_empty", sb.size(), 32'd0);

    // Release sampled on the same edge as cnt==LONG_CYC-1: release wins.
    @(negedge clk);
    key_flag = 1'b1;
    f = cyc + 1;
    @(negedge clk);
    key_flag  = 1'b0;
    key_state = 1'b1;
    wait_cyc(f + LONG_CYC - 1);
    key_state = 1'b0;
    w = f + LONG_CYC;
    sb.push_back('{2'b00, w + DBL_CYC});
    wait_cyc(w);
    check("b1_in_wait2", {31'b0, busy}, 32'd1);
    wait_cyc(w + DBL_CYC + 5);
    check("b1_sb_empty", sb.size(), 32'd0);

    // Second flag sampled on the same edge as cnt==DBL_WIN_CYC-1: double wins.
    @(negedge clk);
    click(10, f, w);
    wait_cyc(w + DBL_CYC - 1);
    key_flag = 1'b1;
    sb.push_back('{2'b01, w + DBL_CYC});
    @(negedge clk);
    key_flag  = 1'b0;
    key_state = 1'b1;
    repeat (5) @(negedge clk);
    key_state = 1'b0;
    @(negedge clk);
    check("b2_idle", {31'b0, busy}, 32'd0);
    wait_cyc(cyc + 60);
    check("b2_sb_empty", sb.size(), 32'd0);

    // Reset in the middle of WAIT2 aborts without an event.
    @(negedge clk);
    click(10, f, w);
    wait_cyc(w + 20);
    rst = 1'b0;
    #1;
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_evt_valid", {31'b0, evt_valid}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    wait_cyc(cyc + 60);
    check("abort_quiet_busy", {31'b0, busy}, 32'd0);
    @(negedge clk);
    click(30, f, w);
    sb.push_back('{2'b00, w + DBL_CYC});
    wait_cyc(w + DBL_CYC + 2);
    check("abort_recover_busy", {31'b0, busy}, 32'd0);
    check("abort_sb_empty", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach the end of the sequence");
    $fatal(1, "watchdog expired");
  end

endmodule
